// File: rtl/seq_array_divider.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock, MSB first.
// Companion to the 4x4 array multiplier; a product divided by one operand returns the other.
module seq_array_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [VW:0]   rem_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          dbz_q;
  logic          busy_q;
  logic          done_q;

  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;
  logic          qbit;
  logic [VW:0]   rem_d;
  logic [DW-1:0] dvd_d;

  // One restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
  always_comb begin
    shifted = {rem_q, dvd_q[DW-1]};
    diff    = shifted - (VW+2)'(dvs_q);
    qbit    = (shifted >= (VW+2)'(dvs_q));
    rem_d   = qbit ? (VW+1)'(diff) : (VW+1)'(shifted);
    dvd_d   = {dvd_q[DW-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            state_q <= (divisor == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CW'(1);
          // Last iteration: the dividend shift register now holds the full quotient.
          if (cnt_q == CW'(DW - 1)) begin
            quotient_q  <= dvd_d;
            remainder_q <= rem_d[VW-1:0];
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        ZERO: begin
          quotient_q  <= '1;
          remainder_q <= '0;
          dbz_q       <= 1'b1;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_array_divider.sv
// Directed bench for seq_array_divider: reset, hand-computed divisions, start-while-busy,
// back-to-back, reset abort, and a full operand sweep checked against the division identity.
module tb_seq_array_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  seq_array_divider #(.DW(8), .VW(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with busy=0; returns at the negedge right after the accepting edge.
  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat);
  endtask

  task automatic check_res(input string tag, input logic [7:0] q, input logic [3:0] r, input logic z);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_quotient"}, quotient, q);
    chk({tag, "_remainder"}, remainder, r);
    chk({tag, "_dbz"}, div_by_zero, z);
  endtask

  task automatic op(input string tag, input logic [7:0] a, input logic [3:0] b,
                    input logic [7:0] q, input logic [3:0] r, input logic z);
    launch(a, b);
    chk({tag, "_busy_run"}, busy, 1'b1);
    wait_done(tag, (b == 4'd0) ? 1 : 8);
    check_res(tag, q, r, z);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int seen;
    int qi, ri, ai, bi;

    // Reset held with start asserted
    rst_n = 1'b0;
    start = 1'b1;
    dividend = 8'd143;
    divisor = 4'd13;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quotient", quotient, 8'd0);
    chk("rst_remainder", remainder, 4'd0);
    chk("rst_dbz", div_by_zero, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);

    op("d143_13", 8'd143, 4'd13, 8'd11, 4'd0, 1'b0);
    op("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    op("d0_5", 8'd0, 4'd5, 8'd0, 4'd0, 1'b0);
    op("d5_0", 8'd5, 4'd0, 8'd255, 4'd0, 1'b1);
    op("d9_3", 8'd9, 4'd3, 8'd3, 4'd0, 1'b0);

    // start pulse with new operands mid-RUN is ignored; outputs hold 9/3 result
    launch(8'd100, 4'd9);
    repeat (2) @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 4'd2;
    @(negedge clk);
    chk("ign_hold_quotient", quotient, 8'd3);
    chk("ign_hold_remainder", remainder, 4'd0);
    chk("ign_busy", busy, 1'b1);
    start = 1'b0;
    wait_done("ign", 5);
    check_res("ign", 8'd11, 4'd1, 1'b0);
    @(negedge clk);
    chk("ign_done_pulse", done, 1'b0);

    // Back-to-back: accept in the done cycle
    launch(8'd200, 4'd7);
    wait_done("b2b_a", 8);
    check_res("b2b_a", 8'd28, 4'd4, 1'b0);
    launch(8'd143, 4'd13);
    chk("b2b_done_clear", done, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    wait_done("b2b_b", 8);
    check_res("b2b_b", 8'd11, 4'd0, 1'b0);
    @(negedge clk);

    // Reset abort at iteration 4
    launch(8'd100, 4'd9);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_quotient", quotient, 8'd0);
    chk("abort_remainder", remainder, 4'd0);
    chk("abort_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_idle_busy", busy, 1'b0);

    // Full sweep, results launched back-to-back
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(8'(a), 4'(b));
        wait_done("sweep", (b == 0) ? 1 : 8);
        qi = int'(quotient);
        ri = int'(remainder);
        ai = a;
        bi = b;
        if (b == 0) begin
          chk("sweep_z_quotient", qi, 255);
          chk("sweep_z_remainder", ri, 0);
          chk("sweep_z_dbz", div_by_zero, 1'b1);
        end else begin
          chk("sweep_identity", qi * bi + ri, ai);
          chk("sweep_rem_lt", (ri < bi) ? 1 : 0, 1);
          chk("sweep_dbz", div_by_zero, 1'b0);
        end
      end
    end
    @(negedge clk);
    chk("final_done_clear", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
